writeback_stage: RTL
====================

// Module: writeback_stage
//
// PURPOSE
//   Final pipeline stage of the rv32i core. Sits directly upstream of the
//   register file and is the only driver of its we/rd_addr/rd_data inputs.
//   Retires ALU results in one cycle. For loads, it waits for the data-memory
//   response, aligns and sign/zero-extends it, then writes. It exports
//   busy/pending_rd so decode can stall on a load-use hazard.
//
// PARAMETERS
//   TIMEOUT_CYCLES  256  max cycles in WAIT_MEM before a load is aborted (>=2)
//
// PORTS
//   clk          in   1         core clock, all state on posedge
//   reset        in   1         synchronous, active-high
//   ex_valid     in   1         execute stage presents a retiring instruction
//   ex_ready     out  1         stage can accept ex_* this cycle
//   ex_kind      in   wb_kind_e WB_NONE / WB_ALU / WB_LOAD
//   ex_rd        in   5         destination register index
//   ex_result    in   32        ALU result (WB_ALU) or load byte address (WB_LOAD)
//   ex_funct3    in   3         load width: LB/LH/LW/LBU/LHU (package enum)
//   mem_rvalid   in   1         data-memory read response valid (1-cycle pulse)
//   mem_rdata    in   32        word-aligned read data
//   we           out  reg_we_e  REG_WE for exactly one cycle per write
//   rd_addr      out  5         register-file write index
//   rd_data      out  32        register-file write data
//   busy         out  1         a load is outstanding (state WAIT_MEM)
//   pending_rd   out  5         rd of the outstanding load, 0 when not busy
//   err_misalign out  1         1-cycle pulse: misaligned LH/LHU/LW dropped
//   err_timeout  out  1         1-cycle pulse: load aborted after TIMEOUT_CYCLES
//
// BEHAVIOUR
//   - Reset: state=IDLE; we=non-write; rd_addr=0; rd_data=0; busy=0;
//     pending_rd=0; err_*=0; timeout counter=0.
//   - FSM IDLE <-> WAIT_MEM. ex_ready = (state==IDLE).
//   - Accept = ex_valid & ex_ready.
//   - Outputs we/rd_addr/rd_data/err_* are registered. we returns to
//     non-write on the cycle after any write.
//   - WB_ALU accepted: next cycle we=REG_WE, rd_addr=ex_rd, rd_data=ex_result.
//     Latency is 1. Back-to-back ALU retires run at 1/cycle.
//   - WB_NONE accepted: no write, no state change.
//   - WB_LOAD accepted, aligned:
//     - capture rd, funct3, addr[1:0]; go to WAIT_MEM; busy=1, pending_rd=rd.
//     - misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
//       It pulses err_misalign next cycle, performs no write and stays IDLE.
//   - WAIT_MEM, mem_rvalid=1: select the lane by the captured offset.
//     - LB/LBU: byte offset*8. LH/LHU: half offset[1]*16. LW: full word.
//     - LB/LH sign-extend; LBU/LHU zero-extend.
//     - Next cycle we=REG_WE with the aligned data; state=IDLE; busy=0.
//     - Load-to-write latency is 1 cycle after mem_rvalid.
//   - WAIT_MEM timeout:
//     - the counter increments each cycle without mem_rvalid.
//     - at TIMEOUT_CYCLES-1 it pulses err_timeout, returns to IDLE, no write.
//     - mem_rvalid on the same cycle as expiry wins: the write happens and
//       there is no error.
//   - mem_rvalid while IDLE is ignored (stale response). No write, no error.
//   - rd==0 (ALU or load): the full handshake runs but we stays non-write.
//     pending_rd stays 0, so no false hazard on x0.
//   - reset asserted during WAIT_MEM: the load is dropped. A response
//     arriving after reset is ignored per the IDLE rule.
//
// STRUCTURE
//   - rv32i package gains wb_kind_e, the load funct3 enum (LB=000, LH=001,
//     LW=010, LBU=100, LHU=101) and the state enum wb_state_e. reg_we_e is
//     reused unchanged.
//   - Sub-module load_align: purely combinational; inputs (funct3, offset,
//     rdata), output 32-bit extended data. Unit-testable on its own.
//
// TESTING
//   1. ALU x5<=0xDEADBEEF, then x6<=0x1 next cycle -> we on two consecutive
//      cycles with the matching rd_addr/rd_data; ex_ready stays 1.
//   2. LB addr 0x...3, mem_rdata=0x80FF_1234 after 3 cycles -> busy=1 and
//      pending_rd=rd during the wait; write 0xFFFF_FF80; LBU same -> 0x0000_0080.
//   3. LH addr 0x...2, rdata=0x8001_7FFF -> 0xFFFF_8001. LH addr 0x...1 ->
//      err_misalign pulse, no we, ex_ready stays 1.
//   4. Load with no mem_rvalid, TIMEOUT_CYCLES=8 -> err_timeout on cycle 8,
//      no write, IDLE. Repeat with mem_rvalid on the expiry cycle -> write,
//      no error.
//   5. rd=0 load and rd=0 ALU op -> never we; pending_rd=0 throughout.
//   6. reset during WAIT_MEM, then mem_rvalid -> no write; the next ALU op
//      writes normally.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared types for the rv32i writeback stage: write-enable, retire kind,
// load widths and FSM states, plus the load alignment check.
package writeback_stage_pkg;

  typedef enum logic {
    REG_NO_WE = 1'b0,
    REG_WE    = 1'b1
  } reg_we_e;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2
  } wb_kind_e;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  function automatic logic load_misaligned(
    input load_funct3_e f3,
    input logic [1:0]   off
  );
    logic mis;
    mis = 1'b0;
    unique case (f3)
      LH, LHU: mis = off[0];
      LW:      mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load lane select and sign/zero extension.
// Purely combinational; offset is the byte address low bits.
module load_align
  import writeback_stage_pkg::*;
(
  input  load_funct3_e funct3,
  input  logic [1:0]   offset,
  input  logic [31:0]  rdata,
  output logic [31:0]  data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{offset, 3'b000} +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    unique case (funct3)
      LB:      data = {{24{b[7]}}, b};
      LBU:     data = {24'b0, b};
      LH:      data = {{16{h[15]}}, h};
      LHU:     data = {16'b0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rv32i writeback stage: retires ALU results, waits on and aligns loads,
// and is the sole driver of the register-file write port.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  wb_kind_e     ex_kind,
  input  logic [4:0]   ex_rd,
  input  logic [31:0]  ex_result,
  input  load_funct3_e ex_funct3,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  output reg_we_e      we,
  output logic [4:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic         busy,
  output logic [4:0]   pending_rd,
  output logic         err_misalign,
  output logic         err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  wb_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         rd_q, rd_d;
  load_funct3_e       f3_q, f3_d;
  logic [1:0]         off_q, off_d;
  reg_we_e            we_q, we_d;
  logic [4:0]         addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               mis_q, mis_d;
  logic               to_q, to_d;
  logic               accept;
  logic [31:0]        load_data;

  load_align u_align (
    .funct3 (f3_q),
    .offset (off_q),
    .rdata  (mem_rdata),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      f3_q    <= LB;
      off_q   <= '0;
      we_q    <= REG_NO_WE;
      addr_q  <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  assign accept = ex_valid && ex_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    off_d   = off_q;
    we_d    = REG_NO_WE;
    addr_d  = addr_q;
    data_d  = data_q;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (ex_kind)
            WB_ALU: begin
              if (ex_rd != 5'd0) begin
                we_d   = REG_WE;
                addr_d = ex_rd;
                data_d = ex_result;
              end
            end
            WB_LOAD: begin
              if (load_misaligned(ex_funct3, ex_result[1:0])) begin
                mis_d = 1'b1;
              end else begin
                state_d = WAIT_MEM;
                cnt_d   = '0;
                rd_d    = ex_rd;
                f3_d    = ex_funct3;
                off_d   = ex_result[1:0];
              end
            end
            default: ;
          endcase
        end
      end
      WAIT_MEM: begin
        // A response on the expiry cycle still completes the load
        if (mem_rvalid) begin
          state_d = IDLE;
          if (rd_q != 5'd0) begin
            we_d   = REG_WE;
            addr_d = rd_q;
            data_d = load_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ex_ready   = (state_q == IDLE);
    busy       = (state_q == WAIT_MEM);
    pending_rd = busy ? rd_q : 5'd0;
  end

  assign we           = we_q;
  assign rd_addr      = addr_q;
  assign rd_data      = data_q;
  assign err_misalign = mis_q;
  assign err_timeout  = to_q;

endmodule
